// File: rtl/tc_ctrl_regfile_axil.sv
// tc_ctrl_regfile_axil
// AXI4-Lite slave register file holding the tensor-core control word
// (start, mixed, compute_type) read by the control poller, plus core
// status and the busy-cycle count of the most recent run.
//
// Register map (addr[3:2], addr above bit 3 must be zero, addr[1:0] ignored):
//   0x00 CTRL    [5:0] RW : start=bit0, mixed=bit1, compute_type=bits[5:2]
//   0x04 STATUS  bit0 busy (live core_busy), bit1 done (sticky, W1C)
//   0x08 CYCLES  busy-cycle count of the last completed run (RO)
//   other        SLVERR, read data 0, writes dropped
//
// Build option: define TC_CYCLE_CNT_EN to include the busy-cycle counter and
// the CYCLES register. Without it 0x08 decodes as unmapped.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   aw*/w*/b*            AXI4-Lite write address, data and response channels
//   ar*/r*               AXI4-Lite read address and data channels
//   core_busy            compute core running (level)
//   core_done            one-cycle pulse at end of a run
//   ctrl_start           CTRL[0], auto-cleared by core_done
//   ctrl_mixed           CTRL[1]
//   ctrl_compute_type    CTRL[5:2] (compute_type_t encoding)

module tc_ctrl_regfile_axil #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    input  logic                    core_busy,
    input  logic                    core_done,
    output logic                    ctrl_start,
    output logic                    ctrl_mixed,
    output logic [3:0]              ctrl_compute_type
);

    // state     | meaning
    // WR_IDLE   | waiting for address and data, both accepted
    // WR_ADDR   | address held, waiting for data
    // WR_DATA   | data held, waiting for address
    // WR_EXEC   | both held, register update happens this cycle
    // WR_RESP   | bvalid high, waiting for bready

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
`ifdef TC_CYCLE_CNT_EN
    localparam logic [1:0] IDX_CYCLES  = 2'd2;
`endif

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    wr_state_t wr_state, wr_state_next;

    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [DATA_WIDTH/8-1:0] w_strb_q;

    logic [5:0] ctrl_q;
    logic       done_q;

    logic wr_fire;
    logic wr_mapped;
    logic wr_ctrl;
    logic wr_status;

    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = 1'b0;
        if ((a >> 4) == '0) begin
            case (a[3:2])
                IDX_CTRL, IDX_STATUS: hit = 1'b1;
`ifdef TC_CYCLE_CNT_EN
                IDX_CYCLES:           hit = 1'b1;
`endif
                default:              hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    // ---------------- write channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        awready       = 1'b0;
        wready        = 1'b0;
        bvalid        = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                awready = 1'b1;
                wready  = 1'b1;
                if (awvalid && wvalid) begin
                    wr_state_next = WR_EXEC;
                end else if (awvalid) begin
                    wr_state_next = WR_ADDR;
                end else if (wvalid) begin
                    wr_state_next = WR_DATA;
                end
            end
            WR_ADDR: begin
                wready = 1'b1;
                if (wvalid) begin
                    wr_state_next = WR_EXEC;
                end
            end
            WR_DATA: begin
                awready = 1'b1;
                if (awvalid) begin
                    wr_state_next = WR_EXEC;
                end
            end
            WR_EXEC: begin
                wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    wr_state_next = WR_IDLE;
                end
            end
            default: begin
                wr_state_next = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_addr_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    always_comb begin
        wr_fire   = (wr_state == WR_EXEC);
        wr_mapped = is_mapped(aw_addr_q);
        // Only byte lane 0 carries live bits in either writable register.
        wr_ctrl   = wr_fire && wr_mapped && w_strb_q[0] && (aw_addr_q[3:2] == IDX_CTRL);
        wr_status = wr_fire && wr_mapped && w_strb_q[0] && (aw_addr_q[3:2] == IDX_STATUS);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bresp <= RESP_OKAY;
        end else if (wr_fire) begin
            bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- registers ----------------
    // A software write to CTRL in the same cycle as core_done wins, start
    // included; done set by core_done wins over a same-cycle W1C.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= w_data_q[5:0];
            end else if (core_done) begin
                ctrl_q[0] <= 1'b0;
            end
            if (core_done) begin
                done_q <= 1'b1;
            end else if (wr_status && w_data_q[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    assign ctrl_start        = ctrl_q[0];
    assign ctrl_mixed        = ctrl_q[1];
    assign ctrl_compute_type = ctrl_q[5:2];

`ifdef TC_CYCLE_CNT_EN
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] cnt_next;
    logic [DATA_WIDTH-1:0] cycles_q;

    // The first busy cycle restarts the count at 1 so a run of N busy cycles
    // reads N. CYCLES takes cnt_next so a done coinciding with the last busy
    // cycle still includes that cycle.
    always_comb begin
        cnt_next = cnt_q;
        if (core_busy && !busy_q) begin
            cnt_next = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end else if (core_busy && (cnt_q != '1)) begin
            cnt_next = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            busy_q <= core_busy;
            cnt_q  <= cnt_next;
            if (core_done) begin
                cycles_q <= cnt_next;
            end
        end
    end
`endif

    // ---------------- read channel ----------------
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (is_mapped(araddr)) begin
            rd_resp = RESP_OKAY;
            case (araddr[3:2])
                IDX_CTRL:   rd_data = {{(DATA_WIDTH-6){1'b0}}, ctrl_q};
                IDX_STATUS: rd_data = {{(DATA_WIDTH-2){1'b0}}, done_q, core_busy};
`ifdef TC_CYCLE_CNT_EN
                IDX_CYCLES: rd_data = cycles_q;
`endif
                default:    rd_data = '0;
            endcase
        end
    end

    assign arready = !rvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
            rresp  <= rd_resp;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, aw_addr_q[1:0], araddr[1:0],
                           w_data_q[DATA_WIDTH-1:6], w_strb_q[DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_tc_ctrl_regfile_axil.sv
// Self-checking bench for tc_ctrl_regfile_axil: directed scenarios plus a
// randomized read/write mix checked against a register-level model.
module tb_tc_ctrl_regfile_axil;

`ifdef TC_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        core_busy, core_done;
    logic        ctrl_start, ctrl_mixed;
    logic [3:0]  ctrl_compute_type;

    tc_ctrl_regfile_axil #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .core_busy(core_busy), .core_done(core_done),
        .ctrl_start(ctrl_start), .ctrl_mixed(ctrl_mixed),
        .ctrl_compute_type(ctrl_compute_type)
    );

    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    // register-level model
    logic [5:0]  m_ctrl;
    logic        m_done;
    logic [31:0] m_cycles;
    logic [31:0] m_run;

    function automatic logic m_mapped(input logic [31:0] a);
        logic [31:0] off;
        off = a & 32'hFFFF_FFFC;
        return (off == 32'h0) || (off == 32'h4) || (CNT_EN && off == 32'h8);
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_mapped(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a & 32'hFFFF_FFFC;
        if (!m_mapped(a)) return 32'h0;
        if (off == 32'h0) return {26'h0, m_ctrl};
        if (off == 32'h4) return {30'h0, m_done, core_busy};
        return m_cycles;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        off = a & 32'hFFFF_FFFC;
        if (m_mapped(a) && s[0]) begin
            if (off == 32'h0) m_ctrl = d[5:0];
            if (off == 32'h4 && d[1]) m_done = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        int n;
        fork
            begin : aw_side
                int k;
                repeat (aw_dly) tick();
                awaddr  = addr;
                awvalid = 1'b1;
                k = 0;
                while (!awready && k < 50) begin tick(); k++; end
                if (!awready) begin
                    vectors++; miscompares++;
                    $display("FAIL aw_timeout: awready got %b required 1", awready);
                end
                tick();
                awvalid = 1'b0;
            end
            begin : w_side
                int k;
                repeat (w_dly) tick();
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                k = 0;
                while (!wready && k < 50) begin tick(); k++; end
                if (!wready) begin
                    vectors++; miscompares++;
                    $display("FAIL w_timeout: wready got %b required 1", wready);
                end
                tick();
                wvalid = 1'b0;
            end
        join
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) begin
            vectors++; miscompares++;
            $display("FAIL b_timeout: bvalid got %b required 1", bvalid);
        end
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: arready got %b required 1", arready);
        end
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) begin
            vectors++; miscompares++;
            $display("FAIL r_timeout: rvalid got %b required 1", rvalid);
        end
        data = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    task automatic run_core(input int len);
        core_busy = 1'b1;
        repeat (len) tick();
        core_busy = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        m_run     = len;
        m_cycles  = len;
        m_ctrl[0] = 1'b0;
        m_done    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        aresetn = 1'b0;
        repeat (3) tick();
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            miscompares++; $display("FAIL reset_handshake: got %b required 11100", {awready, wready, arready, bvalid, rvalid});
        end
        vectors++;
        if ({bresp, rresp} !== 4'b0000 || rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_resp_data: got %b/%h required 0000/0", {bresp, rresp}, rdata);
        end
        vectors++;
        if ({ctrl_compute_type, ctrl_mixed, ctrl_start} !== 6'h0) begin
            miscompares++; $display("FAIL reset_ctrl: got %h required 0", {ctrl_compute_type, ctrl_mixed, ctrl_start});
        end
        vectors++;
        aresetn = 1'b1;
        tick();
        m_ctrl = '0; m_done = 1'b0; m_cycles = '0; m_run = '0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            axi_read(a, d, r);
            if (d !== m_read(a) || r !== m_resp(a)) begin
                miscompares++; $display("FAIL reset_read @%h: got %h/%b required %h/%b", a, d, r, m_read(a), m_resp(a));
            end
            vectors++;
        end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h0, 32'h0000_0025, 4'hF, 0, 2, r);
        m_write(32'h0, 32'h0000_0025, 4'hF);
        if (r !== 2'b00) begin
            miscompares++; $display("FAIL ctrl_write_bresp: got %b required 00", r);
        end
        vectors++;
        if (ctrl_start !== 1'b1 || ctrl_mixed !== 1'b0 || ctrl_compute_type !== 4'h9) begin
            miscompares++; $display("FAIL ctrl_write_outputs: got %b %b %h required 1 0 9", ctrl_start, ctrl_mixed, ctrl_compute_type);
        end
        vectors++;
        axi_read(32'h0, d, r);
        if (d !== 32'h25 || r !== 2'b00) begin
            miscompares++; $display("FAIL ctrl_readback: got %h/%b required 00000025/00", d, r);
        end
        vectors++;
    endtask

    task automatic test_busy_status();
        logic [31:0] d;
        logic [1:0]  r;
        core_busy = 1'b1;
        tick();
        axi_read(32'h4, d, r);
        if (d !== {30'h0, m_done, 1'b1} || r !== 2'b00) begin
            miscompares++; $display("FAIL status_busy: got %h/%b required %h/00", d, r, {30'h0, m_done, 1'b1});
        end
        vectors++;
        core_busy = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_done_cycles();
        logic [31:0] d;
        logic [1:0]  r;
        run_core(7);
        if (ctrl_start !== 1'b0) begin
            miscompares++; $display("FAIL done_autoclear: ctrl_start got %b required 0", ctrl_start);
        end
        vectors++;
        axi_read(32'h4, d, r);
        if (d !== 32'h2 || r !== 2'b00) begin
            miscompares++; $display("FAIL done_status: got %h/%b required 00000002/00", d, r);
        end
        vectors++;
        axi_read(32'h8, d, r);
        if (d !== m_read(32'h8) || r !== m_resp(32'h8)) begin
            miscompares++; $display("FAIL cycles_7: got %h/%b required %h/%b", d, r, m_read(32'h8), m_resp(32'h8));
        end
        vectors++;
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(1, 4)) tick();
            run_core(int'($urandom_range(1, 20)));
            axi_read(32'h8, d, r);
            if (d !== m_read(32'h8) || r !== m_resp(32'h8)) begin
                miscompares++; $display("FAIL cycles_rand: got %h/%b required %h/%b", d, r, m_read(32'h8), m_resp(32'h8));
            end
            vectors++;
        end
    endtask

    // Drives aw and w together, then pulses core_done on the cycle the write
    // lands (the write lands on the edge that raises bvalid).
    task automatic write_with_done(input logic [31:0] a, input logic [31:0] dat);
        awaddr = a; wdata = dat; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            miscompares++; $display("FAIL race_b: got %b/%b required 1/00", bvalid, bresp);
        end
        vectors++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        logic [1:0]  r;
        write_with_done(32'h4, 32'h2);
        m_ctrl[0] = 1'b0;
        m_done    = 1'b1;
        m_cycles  = m_run;
        axi_read(32'h4, d, r);
        if (d !== 32'h2) begin
            miscompares++; $display("FAIL w1c_race: got %h required 00000002", d);
        end
        vectors++;
        axi_write(32'h4, 32'h2, 4'hF, 0, 0, r);
        m_write(32'h4, 32'h2, 4'hF);
        axi_read(32'h4, d, r);
        if (d !== 32'h0 || r !== 2'b00) begin
            miscompares++; $display("FAIL w1c_clear: got %h/%b required 00000000/00", d, r);
        end
        vectors++;
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h40, 32'h1, 4'hF, 1, 0, r);
        if (r !== 2'b10) begin
            miscompares++; $display("FAIL unmapped_bresp: got %b required 10", r);
        end
        vectors++;
        if ({ctrl_compute_type, ctrl_mixed, ctrl_start} !== m_ctrl) begin
            miscompares++; $display("FAIL unmapped_ctrl: got %h required %h", {ctrl_compute_type, ctrl_mixed, ctrl_start}, m_ctrl);
        end
        vectors++;
        axi_read(32'hC, d, r);
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++; $display("FAIL unmapped_read: got %h/%b required 00000000/10", d, r);
        end
        vectors++;
    endtask

    task automatic test_backpressure();
        logic [31:0] dat, old;
        dat = $urandom;
        dat[5:0] = ~m_ctrl;
        old = {26'h0, m_ctrl};
        awaddr = 32'h0; wdata = dat; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b1) begin
            miscompares++; $display("FAIL bp_ready_after_accept: got %b%b%b required 001", awready, wready, arready);
        end
        vectors++;
        araddr = 32'h0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || rvalid !== 1'b1 || rdata !== old || rresp !== 2'b00) begin
                miscompares++; $display("FAIL bp_hold cyc%0d: got b%b/%b r%b/%h/%b required b1/00 r1/%h/00", i, bvalid, bresp, rvalid, rdata, rresp, old);
            end
            vectors++;
            if ({awready, wready, arready} !== 3'b000) begin
                miscompares++; $display("FAIL bp_ready_low cyc%0d: got %b required 000", i, {awready, wready, arready});
            end
            vectors++;
            if (i < 5) tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        m_write(32'h0, dat, 4'hF);
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
            miscompares++; $display("FAIL bp_release: got %b required 00111", {bvalid, rvalid, awready, wready, arready});
        end
        vectors++;
        if ({ctrl_compute_type, ctrl_mixed, ctrl_start} !== m_ctrl) begin
            miscompares++; $display("FAIL bp_ctrl: got %h required %h", {ctrl_compute_type, ctrl_mixed, ctrl_start}, m_ctrl);
        end
        vectors++;
    endtask

    task automatic test_start_race();
        logic [31:0] dat;
        dat = $urandom;
        dat[0] = 1'b1;
        write_with_done(32'h0, dat);
        m_done   = 1'b1;
        m_cycles = m_run;
        m_ctrl   = dat[5:0];
        if (ctrl_start !== 1'b1 || {ctrl_compute_type, ctrl_mixed, ctrl_start} !== m_ctrl) begin
            miscompares++; $display("FAIL start_race: got %h required %h", {ctrl_compute_type, ctrl_mixed, ctrl_start}, m_ctrl);
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [31:0] a, dat, d;
        logic [3:0]  s;
        logic [1:0]  r;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                4: a = 32'h40;
                default: a = $urandom;
            endcase
            if (a < 32'h10) a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                dat = $urandom;
                s   = 4'($urandom_range(0, 15));
                axi_write(a, dat, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
                m_write(a, dat, s);
                if (r !== m_resp(a)) begin
                    miscompares++; $display("FAIL rand_bresp @%h: got %b required %b", a, r, m_resp(a));
                end
                vectors++;
                if ({ctrl_compute_type, ctrl_mixed, ctrl_start} !== m_ctrl) begin
                    miscompares++; $display("FAIL rand_ctrl @%h strb %h: got %h required %h", a, s, {ctrl_compute_type, ctrl_mixed, ctrl_start}, m_ctrl);
                end
                vectors++;
            end else begin
                axi_read(a, d, r);
                if (d !== m_read(a) || r !== m_resp(a)) begin
                    miscompares++; $display("FAIL rand_read @%h: got %h/%b required %h/%b", a, d, r, m_read(a), m_resp(a));
                end
                vectors++;
            end
            if ($urandom_range(0, 7) == 0) begin
                core_done = 1'b1;
                tick();
                core_done = 1'b0;
                m_ctrl[0] = 1'b0;
                m_done    = 1'b1;
                m_cycles  = m_run;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h0, 32'h3F, 4'h1, 0, 0, r);
        m_write(32'h0, 32'h3F, 4'h1);
        awaddr = 32'h0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        araddr = 32'h0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        if (rvalid !== 1'b1 || awready !== 1'b0 || rdata !== 32'h3F) begin
            miscompares++; $display("FAIL mid_setup: got r%b aw%b %h required r1 aw0 0000003f", rvalid, awready, rdata);
        end
        vectors++;
        aresetn = 1'b0;
        #1;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            miscompares++; $display("FAIL mid_reset_handshake: got %b required 11100", {awready, wready, arready, bvalid, rvalid});
        end
        vectors++;
        if ({bresp, rresp} !== 4'b0 || rdata !== 32'h0 || {ctrl_compute_type, ctrl_mixed, ctrl_start} !== 6'h0) begin
            miscompares++; $display("FAIL mid_reset_values: got %b %h %h required 0000 0 0", {bresp, rresp}, rdata, {ctrl_compute_type, ctrl_mixed, ctrl_start});
        end
        vectors++;
        tick();
        aresetn = 1'b1;
        tick();
        m_ctrl = '0; m_done = 1'b0; m_cycles = '0; m_run = '0;
        axi_read(32'h4, d, r);
        if (d !== 32'h0 || r !== 2'b00) begin
            miscompares++; $display("FAIL mid_reset_status: got %h/%b required 00000000/00", d, r);
        end
        vectors++;
        axi_read(32'h8, d, r);
        if (d !== m_read(32'h8) || r !== m_resp(32'h8)) begin
            miscompares++; $display("FAIL mid_reset_cycles: got %h/%b required %h/%b", d, r, m_read(32'h8), m_resp(32'h8));
        end
        vectors++;
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = 3'b000;
        wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
        bready  = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = 3'b000;
        rready  = 1'b0;
        core_busy = 1'b0; core_done = 1'b0;
        m_ctrl = '0; m_done = 1'b0; m_cycles = '0; m_run = '0;

        test_reset();
        test_ctrl_write();
        test_busy_status();
        test_done_cycles();
        test_w1c_race();
        test_unmapped();
        test_backpressure();
        test_start_race();
        test_random();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
